// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral: FSM states, mode bit positions, word width.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
  localparam int SPI_DATA_W = 16;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one SPI pin, with registered level and edge strobes.
module spi_input_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;

  // Strobes and level are registered together so they stay aligned for the consumer.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync  <= {STAGES{RST_VAL}};
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], d};
      level <= sync[STAGES-1];
      rise  <= sync[STAGES-1] & ~level;
      fall  <= ~sync[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi_slave_peripheral.sv
// SPI slave endpoint: oversampled bus, configurable mode/length/bit order,
// one-deep TX holding register, multi-word frames with sticky error flags.
module spi_slave_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int MAX_WORDS_PER_CS = 8,
  localparam int CNT_W           = $clog2(MAX_WORDS_PER_CS + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [1:0]       i_spi_mode,
  input  logic [3:0]       i_data_length,
  input  logic             i_TX_MSB_first,
  input  logic             i_RX_MSB_first,
  input  logic [15:0]      i_TX_Data,
  input  logic             i_TX_DV,
  output logic             o_TX_Ready,
  output logic             o_RX_DV,
  output logic [15:0]      o_RX_Data,
  output logic [CNT_W-1:0] o_RX_Count,
  output logic             o_Busy,
  output logic             o_TX_Underrun,
  output logic             o_Frame_Err,
  input  logic             i_Clr_Flags,
  input  logic             i_SPI_Clk,
  input  logic             i_SPI_MOSI,
  input  logic             i_SPI_CS_n,
  output logic             o_SPI_MISO,
  output logic             o_SPI_MISO_En
);

  spi_state_t state;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
  logic cs_lvl_unused, cs_rise, cs_fall;

  logic [1:0]  mode_q;
  logic [3:0]  len_q;
  logic        tx_msb_q, rx_msb_q;
  logic [3:0]  bit_cnt;
  logic [15:0] tx_sh, rx_sh, rx_next, load_word;
  logic        hold_full;
  logic [15:0] hold_data;
  logic        lead, trail, sample, drive, cs_fall_go, word_done, consume;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .d(i_SPI_Clk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .d(i_SPI_MOSI),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .d(i_SPI_CS_n),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall));

  // Returns {next MISO bit, shifted register}; MSB-first reads bit 'len' then shifts left.
  function automatic logic [16:0] pop_word(input logic [15:0] w, input logic [3:0] len,
                                           input logic msb);
    return msb ? {w[len], w << 1} : {w[0], w >> 1};
  endfunction

  always_comb begin
    lead       = mode_q[CPOL_BIT] ? sclk_fall : sclk_rise;
    trail      = mode_q[CPOL_BIT] ? sclk_rise : sclk_fall;
    sample     = mode_q[CPHA_BIT] ? trail : lead;
    drive      = mode_q[CPHA_BIT] ? lead : trail;
    cs_fall_go = (state == IDLE) && cs_fall;
    word_done  = (state == ACTIVE) && !cs_rise && sample && (bit_cnt == len_q);
    consume    = cs_fall_go || word_done;
    load_word  = hold_full ? hold_data : 16'h0000;
    rx_next    = rx_msb_q ? {rx_sh[14:0], mosi_lvl}
                          : ((rx_sh >> 1) | (16'(mosi_lvl) << len_q));
  end

  // Holding register: a consume on an empty register leaves a same-cycle write intact.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hold_full <= 1'b0;
      hold_data <= 16'h0000;
    end else begin
      if (consume && hold_full) hold_full <= 1'b0;
      if (i_TX_DV && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= i_TX_Data;
      end
    end
  end
  assign o_TX_Ready = ~hold_full;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_TX_Underrun <= 1'b0;
      o_Frame_Err   <= 1'b0;
    end else if (i_Clr_Flags) begin
      o_TX_Underrun <= 1'b0;
      o_Frame_Err   <= 1'b0;
    end else begin
      if (consume && !hold_full) o_TX_Underrun <= 1'b1;
      if ((state == ACTIVE) && cs_rise && (bit_cnt != 4'd0)) o_Frame_Err <= 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state      <= IDLE;
      mode_q     <= 2'b00;
      len_q      <= 4'd0;
      tx_msb_q   <= 1'b1;
      rx_msb_q   <= 1'b1;
      bit_cnt    <= 4'd0;
      tx_sh      <= 16'h0000;
      rx_sh      <= 16'h0000;
      o_RX_DV    <= 1'b0;
      o_RX_Data  <= 16'h0000;
      o_RX_Count <= '0;
      o_Busy     <= 1'b0;
      o_SPI_MISO <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          mode_q     <= i_spi_mode;
          len_q      <= i_data_length;
          tx_msb_q   <= i_TX_MSB_first;
          rx_msb_q   <= i_RX_MSB_first;
          bit_cnt    <= 4'd0;
          rx_sh      <= 16'h0000;
          o_RX_Count <= '0;
          o_Busy     <= 1'b1;
          state      <= ACTIVE;
          if (!i_spi_mode[CPHA_BIT])
            {o_SPI_MISO, tx_sh} <= pop_word(load_word, i_data_length, i_TX_MSB_first);
          else
            tx_sh <= load_word;
        end
        ACTIVE: begin
          if (cs_rise) begin
            state      <= IDLE;
            o_Busy     <= 1'b0;
            o_SPI_MISO <= 1'b0;
          end else begin
            if (sample) begin
              if (bit_cnt == len_q) begin
                o_RX_DV   <= 1'b1;
                o_RX_Data <= rx_next;
                rx_sh     <= 16'h0000;
                bit_cnt   <= 4'd0;
                tx_sh     <= load_word;
                if (o_RX_Count != CNT_W'(MAX_WORDS_PER_CS)) o_RX_Count <= o_RX_Count + 1'b1;
              end else begin
                rx_sh   <= rx_next;
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            if (drive) {o_SPI_MISO, tx_sh} <= pop_word(tx_sh, len_q, tx_msb_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign o_SPI_MISO_En = o_Busy;

endmodule
